// File: rtl/mem_wait_port.sv
// mem_wait_port: single-port memory with WAIT_CYCLES wait states, ready/err pulses.
// Optional MEM_PARITY_EN adds per-word even parity and a sticky parity_err output.
module mem_wait_port #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
`ifdef MEM_PARITY_EN
  output logic              parity_err,
`endif
  output logic              err
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] d_q;
  logic wr_q;
  logic accept, go;
  logic [DATA_W-1:0] mem [0:2**ADDR_W-1];
`ifdef MEM_PARITY_EN
  logic par_mem [0:2**ADDR_W-1];
`endif
  assign accept = (state == IDLE) && (mem_read ^ mem_write);
  assign go     = (state == ACCESS) && (cnt == 4'd0);
  assign ready  = (state == DONE);
  assign busy   = (state != IDLE);
  always_comb begin
    state_nx = (state == DONE) ? IDLE : go ? DONE : accept ? ACCESS : state;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rdata <= '0;
      err   <= 1'b0;
`ifdef MEM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      err   <= (state == IDLE) && mem_read && mem_write;
      if (accept) cnt <= 4'(WAIT_CYCLES);
      else if (state == ACCESS && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (go && !wr_q) rdata <= mem[a_q];
`ifdef MEM_PARITY_EN
      if (go && !wr_q && ((^mem[a_q]) != par_mem[a_q])) parity_err <= 1'b1;
`endif
    end
  end
  // Request fields are held unreset; they only matter once a request is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= addr;
      d_q  <= wdata;
      wr_q <= mem_write;
    end
  end
  // Gating with rst drops a write whose completion edge coincides with reset.
  always_ff @(posedge clk) begin
    if (rst && go && wr_q) begin
      mem[a_q] <= d_q;
`ifdef MEM_PARITY_EN
      par_mem[a_q] <= ^d_q;
`endif
    end
  end
endmodule

// File: tb/tb_mem_wait_port.sv
// tb_mem_wait_port: directed + randomized checks against a word-level memory model.
module tb_mem_wait_port;
  localparam int W = 2;
  logic clk = 0, rst = 0;
  logic mem_read = 0, mem_write = 0, err, ready, busy;
  logic [9:0] addr = 0;
  logic [15:0] wdata = 0, rdata;
  logic mem_read0 = 0, mem_write0 = 0, err0, ready0, busy0;
  logic [9:0] addr0 = 0;
  logic [15:0] wdata0 = 0, rdata0;
`ifdef MEM_PARITY_EN
  logic parity_err, parity_err0;
`endif
  int checks = 0, failures = 0;
  logic [15:0] model [int];
  logic [15:0] exp_r = 0;

  always #5 clk = ~clk;

  mem_wait_port #(.DATA_W(16), .ADDR_W(10), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy),
`ifdef MEM_PARITY_EN
    .parity_err(parity_err),
`endif
    .err(err));

  mem_wait_port #(.DATA_W(16), .ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_read(mem_read0), .mem_write(mem_write0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata0), .ready(ready0), .busy(busy0),
`ifdef MEM_PARITY_EN
    .parity_err(parity_err0),
`endif
    .err(err0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One request, then garbage on the inputs while the access is in flight.
  task automatic access(input bit rd, input bit wr, input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    @(negedge clk);
    mem_read = 0; mem_write = 0; addr = 10'($urandom); wdata = 16'($urandom);
    for (int k = 1; k <= W + 2; k++) begin
      if (k == W + 2) begin
        if (wr) model[int'(a)] = d;
        else exp_r = model[int'(a)];
      end
      chk("busy", 32'(busy), 32'(1));
      chk("ready", 32'(ready), 32'(k == W + 2));
      chk("rdata", 32'(rdata), 32'(exp_r));
      @(negedge clk);
    end
    chk("busy_after", 32'(busy), 32'(0));
    chk("ready_after", 32'(ready), 32'(0));
  endtask

  initial begin
    logic [9:0] pool [8];
    pool = '{10'h004, 10'h3FF, 10'h000, 10'h001, 10'h155, 10'h2AA, 10'h100, 10'h07F};
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_rdata0", 32'(rdata0), 0);
    rst = 1;
    // Zero-wait port with the request held: one access every three cycles.
    for (int k = 0; k < 18; k++) begin
      if (k == 0) begin mem_write0 = 1; addr0 = 10'h007; wdata0 = 16'h0055; end
      if (k == 9) begin mem_write0 = 0; mem_read0 = 1; end
      chk("b2b_busy", 32'(busy0), 32'((k % 3) != 0));
      chk("b2b_ready", 32'(ready0), 32'((k % 3) == 2));
      chk("b2b_rdata", 32'(rdata0), (k >= 11) ? 32'h55 : 32'h0);
      @(negedge clk);
    end
    mem_read0 = 0;
    access(0, 1, 10'h004, 16'hA5C3);
    access(1, 0, 10'h004, 16'h0000);
    chk("rd_a5c3", 32'(rdata), 32'hA5C3);
    // Both requests together: err pulse, nothing else moves.
    @(negedge clk);
    mem_read = 1; mem_write = 1; addr = 10'h004; wdata = 16'hFFFF;
    @(negedge clk);
    mem_read = 0; mem_write = 0;
    chk("err_pulse", 32'(err), 1);
    chk("err_busy", 32'(busy), 0);
    chk("err_ready", 32'(ready), 0);
    chk("err_rdata", 32'(rdata), 32'hA5C3);
    @(negedge clk);
    chk("err_clear", 32'(err), 0);
    chk("err_busy2", 32'(busy), 0);
    access(1, 0, 10'h004, 16'h0000);
    // Reset in the second ACCESS cycle drops the pending write.
    access(0, 1, 10'h3FF, 16'hBEEF);
    @(negedge clk);
    mem_write = 1; addr = 10'h3FF; wdata = 16'h1234;
    @(negedge clk);
    mem_write = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    exp_r = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(ready), 0);
    chk("abort_rdata", 32'(rdata), 0);
    access(1, 0, 10'h3FF, 16'h0000);
    chk("abort_keep", 32'(rdata), 32'hBEEF);
    for (int n = 0; n < 30; n++) begin
      logic [9:0] a;
      a = pool[$urandom_range(7)];
      if (model.exists(int'(a)) && $urandom_range(1) == 1) access(1, 0, a, 16'h0000);
      else access(0, 1, a, 16'($urandom));
    end
`ifdef MEM_PARITY_EN
    chk("par_clean", 32'(parity_err), 0);
    @(negedge clk);
    dut.par_mem[4] = ~dut.par_mem[4];
    access(1, 0, 10'h004, 16'h0000);
    chk("par_set", 32'(parity_err), 1);
    repeat (3) @(negedge clk);
    chk("par_sticky", 32'(parity_err), 1);
    rst = 0;
    @(negedge clk);
    rst = 1;
    chk("par_rst", 32'(parity_err), 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_wait_port.md
MEM_WAIT_PORT -- requirements
Module: mem_wait_port

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width.
REQ-002 SHALL have parameter ADDR_W, default 10, word address width; depth 2**ADDR_W words.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, extra wait states per access; legal range 0..15.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port mem_read  input  1  read request from datapath.
REQ-007 SHALL have port mem_write  input  1  write request from datapath.
REQ-008 SHALL have port addr  input  ADDR_W  word address.
REQ-009 SHALL have port wdata  input  DATA_W  write data.
REQ-010 SHALL have port rdata  output  DATA_W  registered read data.
REQ-011 SHALL have port ready  output  1  one-cycle pulse; access complete.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port err  output  1  one-cycle pulse; illegal request (read and write together).

Function
REQ-014 SHALL implement states IDLE, ACCESS, DONE.
REQ-015 In IDLE, with exactly one of mem_read/mem_write high, SHALL latch addr, wdata and op, load the wait counter with WAIT_CYCLES, and go to ACCESS.
REQ-016 In ACCESS with counter nonzero, SHALL decrement the counter and remain in ACCESS.
REQ-017 In ACCESS with counter zero, SHALL perform the access (write: store latched wdata at latched addr; read: load rdata from latched addr) and go to DONE.
REQ-018 In DONE, SHALL drive ready=1 for exactly that cycle and go to IDLE.
REQ-019 Latency: request in cycle 0 SHALL produce ready and valid rdata in cycle WAIT_CYCLES+2 (cycle 2 when WAIT_CYCLES=0).
REQ-020 SHALL ignore mem_read/mem_write/addr/wdata while in ACCESS or DONE; latched values govern the access.
REQ-021 Back-to-back: a request held high through DONE SHALL be accepted in the following IDLE cycle, i.e. no request is accepted in the DONE cycle itself.
REQ-022 With both mem_read and mem_write high in IDLE, SHALL perform no access, pulse err for one cycle and remain in IDLE.
REQ-023 rdata SHALL hold the last completed read value; writes and err cycles SHALL NOT change it.
REQ-024 A read following a completed write to the same address SHALL return the written data.
REQ-025 All addresses 0..2**ADDR_W-1 SHALL be valid; no out-of-range case exists.

Reset
REQ-026 With rst=0 at a clock edge, SHALL set state=IDLE, counter=0, rdata=0, ready=0, busy=0, err=0.
REQ-027 Reset during ACCESS or DONE SHALL abort the pending access; a pending write SHALL NOT be performed.
REQ-028 Memory array contents SHALL NOT be altered by reset.

Configuration
REQ-029 With macro MEM_PARITY_EN defined, SHALL store one even-parity bit per word on write, check it on read completion, and add port parity_err (output, 1 bit), set sticky on mismatch in the DONE cycle and cleared only by reset.
REQ-030 Without MEM_PARITY_EN, SHALL have no parity storage, no check and no parity_err port; all other behaviour identical.

Verification
REQ-031 Reset then write 16'hA5C3 to addr 10'h004 (WAIT_CYCLES=2) -> busy cycles 1-4, ready high only in cycle 4, rdata stays 16'h0000.
REQ-032 Read addr 10'h004 after REQ-031 -> ready in cycle 4 after request, rdata=16'hA5C3 from that cycle onward.
REQ-033 mem_read=mem_write=1 in IDLE -> err=1 for one cycle, busy=0, memory and rdata unchanged.
REQ-034 Write 16'h1234 to 10'h3FF, rst=0 asserted in second ACCESS cycle, then read 10'h3FF -> returns prior contents, not 16'h1234.
REQ-035 WAIT_CYCLES=0, mem_read held high continuously -> ready pulses every 3 cycles, busy low one cycle between accesses.
REQ-036 With MEM_PARITY_EN, force a stored parity bit inverted, then read that word -> parity_err rises in the DONE cycle and remains 1 until rst=0.
